// File: rtl/watch_cmd_ctrl_if.sv
// watch_cmd_ctrl_if: button, UART FIFO and stopwatch control signals of the watch command controller.
interface watch_cmd_ctrl_if;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       btn_change;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       enable;
    logic       clear;
    logic       change;
    logic       cmd_err;
    modport master(output btn_run_stop, btn_clear, btn_change, rx_empty, rx_data,
                   input rd_en, enable, clear, change, cmd_err);
    modport slave(input btn_run_stop, btn_clear, btn_change, rx_empty, rx_data,
                  output rd_en, enable, clear, change, cmd_err);
endinterface

// File: rtl/watch_cmd_ctrl.sv
// watch_cmd_ctrl: merges button pulses and UART command bytes into stopwatch run/clear/mode control.
module watch_cmd_ctrl #(
    parameter int EN_UART = 1
) (
    input logic            clk,
    input logic            reset,
    watch_cmd_ctrl_if.slave bus
);
    typedef enum logic [1:0] {STOP, RUN, CLR} state_t;
    typedef enum logic [2:0] {C_NONE, C_RS, C_GO, C_HALT, C_CLR, C_MODE, C_ERR} cmd_t;
    state_t     state, nxt, base;
    cmd_t       cmd, ucmd;
    logic       btn_any;
    logic [7:0] uc;
    assign btn_any = bus.btn_run_stop | bus.btn_clear | bus.btn_change;
    // a button owns the cycle, so the FIFO head stays put and is retried next cycle
    assign bus.rd_en = (EN_UART != 0) && reset && !bus.rx_empty && !btn_any;
    // clearing bit 5 folds lowercase letters onto uppercase; no other byte can alias a command letter
    assign uc = bus.rx_data & 8'hDF;
    always_comb begin
        ucmd = uc == 8'h52 ? C_RS   :
               uc == 8'h47 ? C_GO   :
               uc == 8'h53 ? C_HALT :
               uc == 8'h43 ? C_CLR  :
               uc == 8'h4D ? C_MODE : C_ERR;
        cmd  = bus.btn_clear    ? C_CLR  :
               bus.btn_run_stop ? C_RS   :
               bus.btn_change   ? C_MODE :
               bus.rd_en        ? ucmd   : C_NONE;
        base = state == CLR ? STOP : state;
        nxt  = cmd == C_RS   ? (state == RUN ? STOP : RUN) :
               cmd == C_GO   ? RUN :
               cmd == C_HALT ? STOP :
               cmd == C_CLR  ? (state == RUN ? RUN : CLR) : base;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= STOP;
            bus.enable  <= 1'b0;
            bus.clear   <= 1'b0;
            bus.change  <= 1'b0;
            bus.cmd_err <= 1'b0;
        end else begin
            state       <= nxt;
            bus.enable  <= nxt == RUN;
            bus.clear   <= nxt == CLR;
            bus.change  <= bus.change ^ (cmd == C_MODE);
            bus.cmd_err <= cmd == C_ERR;
        end
    end
endmodule
